fp_normalize_pack: RTL and testbench

//  Back end of the single-precision add/sub datapath.
//  - Consumes the raw 26-bit mantissa sum/difference, the working exponent and the result sign.
//  - Normalises iteratively: one left shift per cycle, or one right shift on carry-out.
//  - Rounds to nearest-even, then packs an IEEE 754 binary32 word.
//  - valid/ready on both sides; one operation in flight at a time.

---
 rtl/fp_normalize_pack_if.sv | 28 ++
 rtl/fp_normalize_pack.sv | 164 ++++++++++++++++
 tb/tb_fp_normalize_pack.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fp_normalize_pack_if.sv
// Handshake and data bundle between the add/sub front end, the
// normalise/round/pack back end, and the result consumer.
interface fp_normalize_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [25:0] in_mant;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        inexact;
  logic        zero;

  // Driver of operands and consumer of results
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
    input  in_ready, out_valid, result, ovf, inexact, zero
  );

  // The normalise/pack block itself
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
    output in_ready, out_valid, result, ovf, inexact, zero
  );
endinterface

// File: rtl/fp_normalize_pack.sv
// Back end of the binary32 add/sub datapath: iterative normalisation
// (one shift per cycle), round-to-nearest-even and IEEE 754 packing.
// One operation in flight; valid/ready handshake on both sides.
module fp_normalize_pack #(
  parameter int unsigned MW = 26,
  parameter int unsigned EW = 8,
  parameter int unsigned FW = 23
) (
  input logic               clk,
  input logic               rst,
  fp_normalize_pack_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            sign_q, sign_d;
  // Two spare bits so carry/round increments past 255 are still visible
  logic [EW+1:0]   exp_q, exp_d;
  logic [MW-1:0]   mant_q, mant_d;
  logic            sticky_q, sticky_d;
  logic            sub_q, sub_d;
  logic            zpath_q, zpath_d;
  logic [31:0]     result_q, result_d;
  logic            ovf_q, ovf_d;
  logic            inexact_q, inexact_d;
  logic            zero_q, zero_d;

  logic            g, lsb, up;
  logic [FW+1:0]   ext;
  logic [EW+1:0]   exp_fin;

  // Rounding datapath: {hidden, frac} + round-up, plus final exponent
  always_comb begin
    g   = mant_q[0];
    lsb = mant_q[1];
    up  = g & (sticky_q | lsb);
    ext = {1'b0, mant_q[MW-2:1]} + {{(FW + 1){1'b0}}, up};
    // Subnormal: exponent field becomes 1 only if rounding reached the hidden bit
    if (sub_q) begin
      exp_fin = {{(EW + 1){1'b0}}, ext[FW]};
    end else begin
      exp_fin = exp_q + {{(EW + 1){1'b0}}, ext[FW+1]};
    end
  end

  // FSM next state, normalisation step and result packing
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    sticky_d  = sticky_q;
    sub_d     = sub_q;
    zpath_d   = zpath_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    inexact_d = inexact_q;
    zero_d    = zero_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          sign_d   = bus.in_sign;
          exp_d    = (bus.in_exp == '0) ? {{(EW + 1){1'b0}}, 1'b1} : {2'b00, bus.in_exp};
          mant_d   = bus.in_mant;
          sticky_d = bus.in_sticky;
          sub_d    = 1'b0;
          zpath_d  = 1'b0;
          state_d  = StNorm;
        end
      end
      StNorm: begin
        if (mant_q == '0) begin
          zpath_d = 1'b1;
          state_d = StRound;
        end else if (mant_q[MW-1]) begin
          mant_d   = {1'b0, mant_q[MW-1:1]};
          exp_d    = exp_q + 1'b1;
          sticky_d = sticky_q | mant_q[0];
          state_d  = StRound;
        end else if (mant_q[MW-2]) begin
          state_d = StRound;
        end else if (exp_q == {{(EW + 1){1'b0}}, 1'b1}) begin
          sub_d   = 1'b1;
          state_d = StRound;
        end else begin
          mant_d = {mant_q[MW-2:0], 1'b0};
          exp_d  = exp_q - 1'b1;
        end
      end
      StRound: begin
        if (zpath_q) begin
          result_d  = 32'h0000_0000;
          ovf_d     = 1'b0;
          inexact_d = sticky_q;
          zero_d    = 1'b1;
        end else if (exp_fin >= {2'b00, {EW{1'b1}}}) begin
          result_d  = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
          ovf_d     = 1'b1;
          inexact_d = 1'b1;
          zero_d    = 1'b0;
        end else begin
          result_d  = {sign_q, exp_fin[EW-1:0], ext[FW+1] ? {FW{1'b0}} : ext[FW-1:0]};
          ovf_d     = 1'b0;
          inexact_d = g | sticky_q;
          zero_d    = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_valid_q && bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    in_ready_d  = (state_d == StIdle);
    // Valid rises one cycle into DONE and drops on the accepting edge
    out_valid_d = (state_q == StDone) && !(out_valid_q && bus.out_ready);
  end

  // State and datapath registers, async active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      sticky_q    <= 1'b0;
      sub_q       <= 1'b0;
      zpath_q     <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      inexact_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      sticky_q    <= sticky_d;
      sub_q       <= sub_d;
      zpath_q     <= zpath_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      inexact_q   <= inexact_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.inexact   = inexact_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed bench for fp_normalize_pack: hand-computed binary32 results,
// latency, backpressure and asynchronous reset.
module tb_fp_normalize_pack;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fp_normalize_pack_if bus ();

  fp_normalize_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation, measure latency from the accept edge, check outputs.
  // With ack=1 out_ready is high and the handshake/return to idle is checked too.
  task automatic run_op(input string tag, input logic sign, input logic [7:0] exp,
                        input logic [25:0] mant, input logic sticky, input int lat,
                        input logic [31:0] res, input logic ovf, input logic inx,
                        input logic zro, input logic ack);
    int cyc;
    @(negedge clk);
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_sign   = sign;
    bus.in_exp    = exp;
    bus.in_mant   = mant;
    bus.in_sticky = sticky;
    bus.out_ready = ack;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        cyc = i;
        break;
      end
    end
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".result"}, bus.result, res);
    chk({tag, ".flags"}, {29'd0, bus.ovf, bus.inexact, bus.zero}, {29'd0, ovf, inx, zro});
    if (ack) begin
      @(posedge clk);
      #1;
      chk({tag, ".post_valid"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, ".post_ready"}, {31'd0, bus.in_ready}, 32'd1);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.in_sticky = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset.result", bus.result, 32'd0);
    chk("reset.flags", {29'd0, bus.ovf, bus.inexact, bus.zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Already normalised 1.0
    run_op("one", 1'b0, 8'd127, {2'b01, 23'h0, 1'b0}, 1'b0, 3, 32'h3F80_0000, 0, 0, 0, 1);
    // Carry out: 11.0 -> 1.1 x 2^1 = 3.0
    run_op("carry", 1'b0, 8'd127, {2'b11, 24'h0}, 1'b0, 3, 32'h4040_0000, 0, 0, 0, 1);
    // 23 left shifts: 2^-23
    run_op("shift23", 1'b0, 8'd127, 26'h000_0002, 1'b0, 26, 32'h3400_0000, 0, 0, 0, 1);
    // One left shift: 0.5
    run_op("shift1", 1'b0, 8'd127, 26'h080_0000, 1'b0, 4, 32'h3F00_0000, 0, 0, 0, 1);
    // Round up carries through the whole fraction
    run_op("rnd_carry", 1'b0, 8'd127, {2'b01, 23'h7FFFFF, 1'b1}, 1'b0, 3, 32'h4000_0000,
           0, 1, 0, 1);
    // Same at the top exponent overflows to +inf
    run_op("ovf", 1'b0, 8'd254, {2'b01, 23'h7FFFFF, 1'b1}, 1'b0, 3, 32'h7F80_0000,
           1, 1, 0, 1);
    // Tie with even lsb stays; tie broken by sticky rounds up
    run_op("tie_even", 1'b1, 8'd127, {2'b01, 23'h0, 1'b1}, 1'b0, 3, 32'hBF80_0000, 0, 1, 0, 1);
    run_op("tie_sticky", 1'b0, 8'd127, {2'b01, 23'h0, 1'b1}, 1'b1, 3, 32'h3F80_0001,
           0, 1, 0, 1);
    // Exact zero: sign forced positive, inexact follows in_sticky
    run_op("zero", 1'b1, 8'd100, 26'h0, 1'b0, 3, 32'h0000_0000, 0, 0, 1, 1);
    run_op("zero_stk", 1'b1, 8'd100, 26'h0, 1'b1, 3, 32'h0000_0000, 0, 1, 1, 1);
    // Subnormal at exp=1
    run_op("subnorm", 1'b0, 8'd1, 26'h000_0100, 1'b0, 3, 32'h0000_0080, 0, 0, 0, 1);
    // Subnormal rounding into the hidden bit gives the smallest normal
    run_op("sub_up", 1'b0, 8'd1, {2'b00, 23'h7FFFFF, 1'b1}, 1'b1, 3, 32'h0080_0000,
           0, 1, 0, 1);

    // Backpressure: result held for 10 cycles with out_ready low
    run_op("bp", 1'b0, 8'd127, {2'b01, 23'h0, 1'b0}, 1'b0, 3, 32'h3F80_0000, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp.hold_result", bus.result, 32'h3F80_0000);
      chk("bp.hold_ctrl", {28'd0, bus.out_valid, bus.in_ready, bus.ovf, bus.inexact},
          {28'd0, 4'b1000});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.released", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);

    // Reset in the middle of a long normalisation
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'd127;
    bus.in_mant   = 26'h000_0002;
    bus.in_sticky = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst.async", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    chk("rst.result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 1'b0, 8'd127, {2'b11, 24'h0}, 1'b0, 3, 32'h4040_0000, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
